// File: rtl/alu_pkg.sv
// Shared encodings for the ALU result writeback path: bundle kinds,
// exception causes and the writeback sequencer state.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 4;
    localparam int HI_REG_DEFAULT = 15;

    typedef enum logic [1:0] {
        WB_NONE   = 2'b00,
        WB_SINGLE = 2'b01,
        WB_MULDIV = 2'b10,
        WB_SWAP   = 2'b11
    } wb_kind_e;

    typedef enum logic [1:0] {
        EXC_NONE  = 2'b00,
        EXC_OVF   = 2'b01,
        EXC_HIREG = 2'b10
    } exc_cause_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WR1  = 2'b01,
        S_WR2  = 2'b10,
        S_EXC  = 2'b11
    } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// Writeback sequencer: takes one ALU result bundle per handshake and issues one
// or two register-file writes, or raises a held exception instead.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int HI_REG = HI_REG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [1:0]        wb_kind,
    input  logic [ADDR_W-1:0] wb_rd1,
    input  logic [ADDR_W-1:0] wb_rd2,
    input  logic [DATA_W-1:0] wb_data1,
    input  logic [DATA_W-1:0] wb_data2,
    input  logic              wb_ovf,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    input  logic              exc_ack
);

    localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(HI_REG);

    wb_state_e         r_state;
    wb_kind_e          r_kind;
    exc_cause_e        r_cause;
    logic [ADDR_W-1:0] r_rd1;
    logic [ADDR_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              r_started;
    logic              w_accept;

    // r_started keeps wb_ready low until the first edge after reset release.
    assign wb_ready = (r_state == S_IDLE) && r_started && rst_n;
    assign w_accept = wb_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_kind    <= WB_NONE;
            r_cause   <= EXC_NONE;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_data1   <= '0;
            r_data2   <= '0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_kind  <= wb_kind_e'(wb_kind);
                        r_rd1   <= wb_rd1;
                        r_rd2   <= wb_rd2;
                        r_data1 <= wb_data1;
                        r_data2 <= wb_data2;
                        if (wb_ovf) begin
                            r_cause <= EXC_OVF;
                            r_state <= S_EXC;
                        end else if (wb_kind == WB_MULDIV && wb_rd1 == HI_ADDR) begin
                            r_cause <= EXC_HIREG;
                            r_state <= S_EXC;
                        end else if (wb_kind == WB_NONE) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WR1;
                        end
                    end
                end
                S_WR1: begin
                    if (r_kind == WB_MULDIV || (r_kind == WB_SWAP && r_rd1 != r_rd2))
                        r_state <= S_WR2;
                    else
                        r_state <= S_IDLE;
                end
                S_WR2: begin
                    r_state <= S_IDLE;
                end
                S_EXC: begin
                    if (exc_ack) begin
                        r_cause <= EXC_NONE;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write port is decoded purely from state and the captured bundle.
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        exc_valid = 1'b0;
        exc_cause = EXC_NONE;
        case (r_state)
            S_WR1: begin
                rf_we    = 1'b1;
                rf_waddr = r_rd1;
                rf_wdata = (r_kind == WB_SWAP) ? r_data2 : r_data1;
            end
            S_WR2: begin
                rf_we = 1'b1;
                if (r_kind == WB_SWAP) begin
                    rf_waddr = r_rd2;
                    rf_wdata = r_data1;
                end else begin
                    rf_waddr = HI_ADDR;
                    rf_wdata = r_data2;
                end
            end
            S_EXC: begin
                exc_valid = 1'b1;
                exc_cause = r_cause;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_alu_writeback;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_kind;
    logic [3:0]  wb_rd1;
    logic [3:0]  wb_rd2;
    logic [15:0] wb_data1;
    logic [15:0] wb_data2;
    logic        wb_ovf;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic        exc_ack;

    int nChecks = 0;
    int nFails  = 0;

    alu_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_kind   (wb_kind),
        .wb_rd1    (wb_rd1),
        .wb_rd2    (wb_rd2),
        .wb_data1  (wb_data1),
        .wb_data2  (wb_data2),
        .wb_ovf    (wb_ovf),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .exc_ack   (exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle with wb_valid high; the next tick accepts it.
    task automatic present(input logic [1:0] kind, input logic [3:0] rd1, input logic [3:0] rd2,
                           input logic [15:0] d1, input logic [15:0] d2, input logic ovf);
        wb_valid = 1'b1;
        wb_kind  = kind;
        wb_rd1   = rd1;
        wb_rd2   = rd2;
        wb_data1 = d1;
        wb_data2 = d2;
        wb_ovf   = ovf;
    endtask

    // Drop valid and scramble the bundle so capture is really exercised.
    task automatic scramble();
        wb_valid = 1'b0;
        wb_kind  = 2'b11;
        wb_rd1   = 4'hE;
        wb_rd2   = 4'hD;
        wb_data1 = 16'hDEAD;
        wb_data2 = 16'hBEEF;
        wb_ovf   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nChecks++;
        if (wb_ready !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== 4'h0 || rf_wdata !== 16'h0 ||
            exc_valid !== 1'b0 || exc_cause !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got ready=%b we=%b addr=%h data=%h exc=%b cause=%b, want all 0",
                     wb_ready, rf_we, rf_waddr, rf_wdata, exc_valid, exc_cause);
        end
        rst_n = 1'b1;
        tick();
        nChecks++;
        if (wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_release_ready: got %b want 1", wb_ready);
        end
    endtask

    task automatic test_single();
        present(WB_SINGLE, 4'd3, 4'd0, 16'h1234, 16'h0000, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 16'h1234 || wb_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_write: got we=%b addr=%0d data=%h ready=%b want 1/3/1234/0",
                     rf_we, rf_waddr, rf_wdata, wb_ready);
        end
        tick();
        nChecks++;
        if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 16'h0 || wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL single_done: got we=%b addr=%0d data=%h ready=%b want 0/0/0000/1",
                     rf_we, rf_waddr, rf_wdata, wb_ready);
        end
    endtask

    task automatic test_muldiv();
        present(WB_MULDIV, 4'd2, 4'd0, 16'h5678, 16'h00AB, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 16'h5678) begin
            nFails++;
            $display("[TB] FAIL muldiv_wr1: got we=%b addr=%0d data=%h want 1/2/5678", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'h00AB || wb_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL muldiv_wr2: got we=%b addr=%0d data=%h ready=%b want 1/15/00ab/0",
                     rf_we, rf_waddr, rf_wdata, wb_ready);
        end
        tick();
        nChecks++;
        if (rf_we !== 1'b0 || wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL muldiv_done: got we=%b ready=%b want 0/1", rf_we, wb_ready);
        end
    endtask

    task automatic test_swap();
        present(WB_SWAP, 4'd4, 4'd9, 16'hAAAA, 16'h5555, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 16'h5555) begin
            nFails++;
            $display("[TB] FAIL swap_wr1: got we=%b addr=%0d data=%h want 1/4/5555", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd9 || rf_wdata !== 16'hAAAA) begin
            nFails++;
            $display("[TB] FAIL swap_wr2: got we=%b addr=%0d data=%h want 1/9/aaaa", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        nChecks++;
        if (rf_we !== 1'b0 || wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL swap_done: got we=%b ready=%b want 0/1", rf_we, wb_ready);
        end
    endtask

    task automatic test_swap_same();
        present(WB_SWAP, 4'd4, 4'd4, 16'hAAAA, 16'h5555, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 16'h5555) begin
            nFails++;
            $display("[TB] FAIL swap_same_wr: got we=%b addr=%0d data=%h want 1/4/5555", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        nChecks++;
        if (rf_we !== 1'b0 || wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL swap_same_single: got we=%b ready=%b want 0/1", rf_we, wb_ready);
        end
    endtask

    task automatic test_overflow();
        present(WB_SINGLE, 4'd1, 4'd0, 16'h7FFF, 16'h0000, 1'b1);
        tick();
        scramble();
        // Valid during EXC must be ignored; ack stays low for five cycles.
        wb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if (rf_we !== 1'b0 || exc_valid !== 1'b1 || exc_cause !== 2'b01 || wb_ready !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL ovf_hold[%0d]: got we=%b exc=%b cause=%b ready=%b want 0/1/01/0",
                         i, rf_we, exc_valid, exc_cause, wb_ready);
            end
            if (i < 4) tick();
        end
        wb_valid = 1'b0;
        exc_ack  = 1'b1;
        tick();
        exc_ack  = 1'b0;
        nChecks++;
        if (exc_valid !== 1'b0 || exc_cause !== 2'b00 || wb_ready !== 1'b1 || rf_we !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ovf_ack: got exc=%b cause=%b ready=%b we=%b want 0/00/1/0",
                     exc_valid, exc_cause, wb_ready, rf_we);
        end
    endtask

    task automatic test_hireg();
        present(WB_MULDIV, 4'd15, 4'd0, 16'h1111, 16'h2222, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b0 || exc_valid !== 1'b1 || exc_cause !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL hireg_exc: got we=%b exc=%b cause=%b want 0/1/10", rf_we, exc_valid, exc_cause);
        end
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        nChecks++;
        if (exc_valid !== 1'b0 || rf_we !== 1'b0 || wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL hireg_ack: got exc=%b we=%b ready=%b want 0/0/1", exc_valid, rf_we, wb_ready);
        end
        // Overflow outranks the HI_REG check.
        present(WB_MULDIV, 4'd15, 4'd0, 16'h1111, 16'h2222, 1'b1);
        tick();
        scramble();
        nChecks++;
        if (exc_valid !== 1'b1 || exc_cause !== 2'b01 || rf_we !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ovf_priority: got exc=%b cause=%b we=%b want 1/01/0", exc_valid, exc_cause, rf_we);
        end
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        present(WB_NONE, 4'd5, 4'd0, 16'h9999, 16'h0000, 1'b0);
        tick();
        nChecks++;
        if (rf_we !== 1'b0 || wb_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL none_no_write: got we=%b ready=%b want 0/1", rf_we, wb_ready);
        end
        present(WB_SINGLE, 4'd7, 4'd0, 16'hBEEF, 16'h0000, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== 16'hBEEF) begin
            nFails++;
            $display("[TB] FAIL b2b_single: got we=%b addr=%0d data=%h want 1/7/beef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask

    task automatic test_single_r15();
        present(WB_SINGLE, 4'd15, 4'd0, 16'h0F0F, 16'h0000, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'h0F0F || exc_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_r15: got we=%b addr=%0d data=%h exc=%b want 1/15/0f0f/0",
                     rf_we, rf_waddr, rf_wdata, exc_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        present(WB_MULDIV, 4'd2, 4'd0, 16'h1111, 16'h2222, 1'b0);
        tick();
        scramble();
        nChecks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 16'h1111) begin
            nFails++;
            $display("[TB] FAIL rstmid_wr1: got we=%b addr=%0d data=%h want 1/2/1111", rf_we, rf_waddr, rf_wdata);
        end
        rst_n = 1'b0;
        tick();
        nChecks++;
        if (rf_we !== 1'b0 || rf_waddr !== 4'd0 || rf_wdata !== 16'h0 || exc_valid !== 1'b0 ||
            exc_cause !== 2'b00 || wb_ready !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL rstmid_abort: got we=%b addr=%0d data=%h exc=%b cause=%b ready=%b want all 0",
                     rf_we, rf_waddr, rf_wdata, exc_valid, exc_cause, wb_ready);
        end
        rst_n = 1'b1;
        tick();
        nChecks++;
        if (wb_ready !== 1'b1 || rf_we !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL rstmid_release: got ready=%b we=%b want 1/0", wb_ready, rf_we);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        exc_ack  = 1'b0;
        wb_valid = 1'b0;
        wb_kind  = 2'b00;
        wb_rd1   = '0;
        wb_rd2   = '0;
        wb_data1 = '0;
        wb_data2 = '0;
        wb_ovf   = 1'b0;
        #2;
        test_reset();
        test_single();
        test_muldiv();
        test_swap();
        test_swap_same();
        test_overflow();
        test_hireg();
        test_back_to_back();
        test_single_r15();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Multi-cycle writeback sequencer on the consumer side of the 16-bit ALU. It accepts one ALU result bundle per handshake and drives the single register-file write port, issuing one or two writes per result. Two writes are needed for MUL/DIV (rd1 plus R15) and for SWAP (rd1 and rd2). It converts the ALU overflow indication and the illegal R15 destination case into a held exception request, with no register writes for that result. It sits between the ALU/execute stage and the register file.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 4, register address width (16 registers)
HI_REG, 15, register index receiving MUL high word / DIV quotient

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
wb_valid  in  1  result bundle valid
wb_ready  out  1  sequencer can accept a bundle
wb_kind  in  2  00 NONE, 01 SINGLE, 10 MULDIV, 11 SWAP
wb_rd1  in  ADDR_W  first destination (op1 register)
wb_rd2  in  ADDR_W  second register (SWAP only)
wb_data1  in  DATA_W  SINGLE: result; MULDIV: low word/remainder; SWAP: old op1 value
wb_data2  in  DATA_W  MULDIV: high word/quotient; SWAP: old op2 value
wb_ovf  in  1  ALU overflow exception for this bundle
rf_we  out  1  register-file write enable
rf_waddr  out  ADDR_W  write address
rf_wdata  out  DATA_W  write data
exc_valid  out  1  exception request, held until acknowledged
exc_cause  out  2  01 overflow, 10 MULDIV targets HI_REG; 00 when exc_valid=0
exc_ack  in  1  exception acknowledge

Behaviour:
- Reset, synchronous with rst_n=0 at a clk edge:
  - state=IDLE; wb_ready=0 while rst_n=0, 1 from the first cycle after release.
  - rf_we=0, rf_waddr=0, rf_wdata=0, exc_valid=0, exc_cause=0.
  - Captured bundle registers cleared.
- States: IDLE, WR1, WR2, EXC. wb_ready=1 only in IDLE. Accept = wb_valid & wb_ready; the bundle is captured on that edge.
- Transitions from IDLE on accept, in priority order:
  - wb_ovf=1 -> EXC, cause 01 (overflow takes priority over every kind).
  - kind MULDIV with rd1==HI_REG -> EXC, cause 10.
  - kind NONE -> stay IDLE, no write.
  - otherwise -> WR1.
- WR1 (one cycle): rf_we=1.
  - SINGLE and MULDIV: waddr=rd1, wdata=data1.
  - SWAP: waddr=rd1, wdata=data2.
  - Next state: SINGLE -> IDLE; MULDIV -> WR2; SWAP with rd1!=rd2 -> WR2; SWAP with rd1==rd2 -> IDLE (single write).
- WR2 (one cycle): rf_we=1.
  - MULDIV: waddr=HI_REG, wdata=data2.
  - SWAP: waddr=rd2, wdata=data1.
  - Next state IDLE.
- EXC: exc_valid=1, exc_cause held, rf_we=0. exc_ack=1 -> IDLE next cycle. exc_ack is ignored in every other state.
- Latency: first write appears the cycle after accept. Throughput: one bundle per 2 cycles (single write), per 3 cycles (double write), or per 1 cycle for NONE.
- rf_we, rf_waddr and rf_wdata are decoded only from state and captured registers, never from live inputs. Inputs may change freely after accept.
- When rf_we=0, rf_waddr and rf_wdata are driven to 0.
- Reset mid-operation (WR1, WR2 or EXC): abort immediately. No remaining write is issued; the pending exception is dropped.
- wb_valid while not ready: ignored; the upstream stage must hold the bundle stable.
- SINGLE targeting HI_REG is legal and writes R15.

Decomposition:
- Shared package alu_pkg holds:
  - wb_kind encodings (WB_NONE/WB_SINGLE/WB_MULDIV/WB_SWAP)
  - exc_cause encodings (EXC_NONE/EXC_OVF/EXC_HIREG)
  - state encoding
  - HI_REG default
- Single module; no sub-module. The FSM and a write-mux are in one block.

Test Plan:
- SINGLE rd1=3, data1=0x1234 -> cycle+1: we=1, waddr=3, wdata=0x1234; wb_ready back to 1 at cycle+2.
- MULDIV rd1=2, data1=0x5678, data2=0x00AB -> writes (2,0x5678) then (15,0x00AB) on consecutive cycles.
- SWAP rd1=4, rd2=9, data1=0xAAAA, data2=0x5555 -> writes (4,0x5555) then (9,0xAAAA). Same bundle with rd2=4 -> single write (4,0x5555).
- SINGLE with wb_ovf=1 -> no we; exc_valid=1, cause=01, held 5 cycles until exc_ack, then IDLE. MULDIV rd1=15 -> cause=10, no write.
- Back-to-back valid with NONE, then SINGLE -> NONE consumes 1 cycle, no write; SINGLE accepted the next cycle.
- rst_n=0 during WR1 of MULDIV -> no R15 write; all outputs 0 on the next cycle; wb_ready=1 one cycle after release.
